// File: rtl/data_memory_stage_pkg.sv
// rtl/data_memory_stage_pkg.sv - shared word type, FSM encoding and LEGv8 opcodes for the MEM stage
package data_memory_stage_pkg;

    localparam int WORD_W = 64;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [7:0]  OP_CBZ  = 8'hB4;
    localparam logic [5:0]  OP_B    = 6'h05;

    // A request that touches memory at all; write wins when both are set.
    function automatic logic is_mem_op(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/data_memory_stage_dmem_array.sv
// rtl/data_memory_stage_dmem_array.sv - single-port doubleword RAM with registered read port
module data_memory_stage_dmem_array
    import data_memory_stage_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  word_t         i_wdata,
    output word_t         o_rdata
);

    word_t r_mem [DEPTH];
    word_t r_rdata;

    // Storage array is never reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register holds its value between loads and clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_stage.sv
// rtl/data_memory_stage.sv - LEGv8 MEM stage: multi-cycle LDUR/STUR FSM and branch resolve (option DMEM_ALIGN_CHECK_EN)
module data_memory_stage
    import data_memory_stage_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  valid_in,
    input  word_t alu_result,
    input  word_t read_data2,
    input  logic  mem_read,
    input  logic  mem_write,
    input  logic  branch,
    input  logic  uncond_branch,
    input  logic  zero,
    input  word_t branch_target,
    output logic  stall,
    output word_t read_data,
    output logic  rd_valid,
    output logic  pc_src,
    output word_t pc_target
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic  align_fault
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    state_t         r_state;
    state_t         w_next_state;
    logic [CW-1:0]  r_count;
    logic [AW-1:0]  r_index;
    word_t          r_wdata;
    logic           r_wr;
    logic           r_rd;
    logic           r_rd_valid;

    logic           w_mem_cmd;
    logic           w_req;
    logic           w_idle;
    logic           w_accept;
    logic           w_last_access;
    logic           w_fire;
    logic [AW-1:0]  w_index;
    logic [AW-1:0]  w_fire_index;
    word_t          w_fire_data;
    logic           w_fire_wr;
    logic           w_fire_rd;
    logic           w_unused_bits;

    assign w_mem_cmd = valid_in & is_mem_op(mem_read, mem_write);

`ifdef DMEM_ALIGN_CHECK_EN
    logic w_misaligned;
    logic r_align_fault;
    assign w_misaligned = (alu_result[2:0] != 3'b000);
    assign w_req        = w_mem_cmd & ~w_misaligned;
`else
    assign w_req        = w_mem_cmd;
`endif

    assign w_index       = alu_result[AW+2:3];
    assign w_unused_bits = ^{alu_result[WORD_W-1:AW+3], alu_result[2:0]};

    assign w_idle        = (r_state == ST_IDLE);
    assign w_accept      = w_idle & w_req;
    // Counter holds the remaining ACCESS cycles; the access lands on the edge leaving the last one.
    assign w_last_access = (r_state == ST_ACCESS) & (r_count == CW'(1));
    // With single-cycle latency there is no ACCESS cycle: the access lands on the accepting edge.
    assign w_fire        = (w_accept & (LATENCY == 1)) | w_last_access;

    assign w_fire_index  = w_idle ? w_index : r_index;
    assign w_fire_data   = w_idle ? read_data2 : r_wdata;
    assign w_fire_wr     = w_idle ? mem_write : r_wr;
    assign w_fire_rd     = w_idle ? (mem_read & ~mem_write) : r_rd;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; DONE always returns to IDLE so the held request is not re-issued.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (LATENCY == 1) ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_last_access) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Latch the request on acceptance and count down the access latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_index <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
        end else if (w_accept) begin
            r_count <= CW'(LATENCY - 1);
            r_index <= w_index;
            r_wdata <= read_data2;
            r_wr    <= mem_write;
            r_rd    <= mem_read & ~mem_write;
        end else if (r_state == ST_ACCESS) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Load-complete pulse, aligned with the RAM read register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_fire & w_fire_rd;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    // Misaligned request seen while idle: one-cycle registered fault, no memory activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_align_fault <= 1'b0;
        end else begin
            r_align_fault <= w_idle & w_mem_cmd & w_misaligned;
        end
    end

    assign align_fault = r_align_fault;
`endif

    data_memory_stage_dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_fire & w_fire_wr),
        .i_re    (w_fire & w_fire_rd),
        .i_addr  (w_fire_index),
        .i_wdata (w_fire_data),
        .o_rdata (read_data)
    );

    assign stall     = w_accept | (r_state == ST_ACCESS);
    assign rd_valid  = r_rd_valid;
    assign pc_src    = valid_in & ((branch & zero) | uncond_branch);
    assign pc_target = branch_target;

endmodule

// File: tb/tb_data_memory_stage.sv
// tb/tb_data_memory_stage.sv - randomized bench with behavioural MEM-stage model (option DMEM_ALIGN_CHECK_EN)
module tb_data_memory_stage;
    import data_memory_stage_pkg::*;

    localparam int DEPTH = 128;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, mem_read, mem_write, branch, uncond_branch, zero;
    logic [63:0] alu_result, read_data2, branch_target;
    logic        stall, rd_valid, pc_src;
    logic [63:0] read_data, pc_target;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        align_fault;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_memory_stage #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .alu_result    (alu_result),
        .read_data2    (read_data2),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .branch        (branch),
        .uncond_branch (uncond_branch),
        .zero          (zero),
        .branch_target (branch_target),
        .stall         (stall),
        .read_data     (read_data),
        .rd_valid      (rd_valid),
        .pc_src        (pc_src),
        .pc_target     (pc_target)
`ifdef DMEM_ALIGN_CHECK_EN
        ,
        .align_fault   (align_fault)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Behavioural model: memory as a plain array indexed by (addr/8) mod DEPTH,
    // a request occupies LAT+1 cycles, stalls the first LAT, and completes at the end of cycle LAT-1.
    logic [63:0] m_mem [DEPTH];
    int          m_left = 0;
    bit          m_done = 0;
    bit          m_rdv  = 0;
    bit          m_af   = 0;
    logic [63:0] m_rd   = '0;
    logic [63:0] m_addr, m_data;
    bit          m_is_wr;

    function automatic int idx(input logic [63:0] a);
        return int'((a >> 3) % DEPTH);
    endfunction

    always @(negedge clk) begin : model
        bit idle, req, mis;
        if (!rst_n) begin
            chk("rst_stall", stall, 0);
            chk("rst_rd_valid", rd_valid, 0);
            chk("rst_read_data", read_data, 0);
            chk("rst_pc_src", pc_src, 0);
`ifdef DMEM_ALIGN_CHECK_EN
            chk("rst_align_fault", align_fault, 0);
`endif
            m_left = 0; m_done = 0; m_rdv = 0; m_af = 0; m_rd = '0;
        end else begin
            idle = (m_left == 0) && !m_done;
            req  = valid_in && (mem_read || mem_write);
            mis  = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
            mis  = (alu_result[2:0] != 3'b000);
`endif
            chk("stall", stall, (idle && req && !mis) || (m_left > 0));
            chk("pc_src", pc_src, valid_in && ((branch && zero) || uncond_branch));
            chk("pc_target", pc_target, branch_target);
            chk("rd_valid", rd_valid, m_rdv);
            chk("read_data", read_data, m_rd);
`ifdef DMEM_ALIGN_CHECK_EN
            chk("align_fault", align_fault, m_af);
`endif
            m_rdv = 0;
            m_af  = 0;
            if (m_done) begin
                m_done = 0;
            end else if (idle && req && mis) begin
                m_af = 1;
            end else if (idle && req) begin
                m_addr  = alu_result;
                m_data  = read_data2;
                m_is_wr = mem_write;
                m_left  = LAT;
            end
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_is_wr) m_mem[idx(m_addr)] = m_data;
                    else begin
                        m_rd  = m_mem[idx(m_addr)];
                        m_rdv = 1;
                    end
                    m_done = 1;
                end
            end
        end
    end

    task automatic set_in(input logic v, input logic rd, input logic wr, input logic br,
                          input logic ub, input logic z, input logic [63:0] a,
                          input logic [63:0] d, input logic [63:0] t);
        valid_in = v; mem_read = rd; mem_write = wr; branch = br;
        uncond_branch = ub; zero = z; alu_result = a; read_data2 = d; branch_target = t;
    endtask

    // Called at posedge+1; holds inputs for the whole occupancy of the request.
    task automatic drive(input logic v, input logic rd, input logic wr, input logic br,
                         input logic ub, input logic z, input logic [63:0] a,
                         input logic [63:0] d, input logic [63:0] t);
        int  n;
        bit  mis;
        set_in(v, rd, wr, br, ub, z, a, d, t);
        mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        mis = (a[2:0] != 3'b000);
`endif
        n = (v && (rd || wr) && !mis) ? LAT + 1 : 1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ld_check(input logic [63:0] a, input logic [63:0] exp, input string name);
        set_in(1, 1, 0, 0, 0, 0, a, 64'h0, 64'h0);
        @(negedge clk);
        chk({name, "_stall_c0"}, stall, 1);
        chk({name, "_rdv_c0"}, rd_valid, 0);
        repeat (LAT - 1) @(negedge clk);
        chk({name, "_stall_clast"}, stall, 1);
        @(negedge clk);
        chk({name, "_stall_done"}, stall, 0);
        chk({name, "_rdv_done"}, rd_valid, 1);
        chk({name, "_data"}, read_data, exp);
        @(posedge clk);
        #1;
        set_in(0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [10:0] ops [4];
        logic [10:0] op;
        logic [63:0] a;
        ops[0] = OP_LDUR;
        ops[1] = OP_STUR;
        ops[2] = {OP_CBZ, 3'b000};
        ops[3] = {OP_B, 5'b00000};

        set_in(0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_read_data", read_data, 64'h0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_stall", stall, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++)
            drive(1, 0, 1, 0, 0, 0, 64'(i) * 64'd8, {$urandom, $urandom}, 64'h0);

        // STUR 520 / LDUR 520 timing
        set_in(1, 0, 1, 0, 0, 0, 64'd520, 64'h1234, 64'h0);
        @(negedge clk); chk("stur_stall_c0", stall, 1);
        @(negedge clk); chk("stur_stall_c1", stall, 1);
        @(negedge clk); chk("stur_stall_c2", stall, 0);
        chk("stur_rdv_c2", rd_valid, 0);
        @(posedge clk); #1;
        ld_check(64'd520, 64'h1234, "ldur520");

`ifdef DMEM_ALIGN_CHECK_EN
        set_in(1, 0, 1, 0, 0, 0, 64'd521, 64'hBEEF, 64'h0);
        @(negedge clk); chk("align_nostall", stall, 0);
        @(posedge clk); #1;
        set_in(0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0);
        @(negedge clk); chk("align_pulse", align_fault, 1);
        @(posedge clk); #1;
        ld_check(64'd520, 64'h1234, "align_ld");
`endif

        // ALU op for five cycles
        set_in(1, 0, 0, 0, 0, 0, 64'h77, 64'h99, 64'h0);
        repeat (5) begin
            @(negedge clk);
            chk("add_stall", stall, 0);
            chk("add_rdv", rd_valid, 0);
            @(posedge clk); #1;
        end

        // Branch resolution
        set_in(1, 0, 0, 1, 0, 1, 64'h0, 64'h0, 64'h40);
        @(negedge clk); chk("cbz_taken", pc_src, 1); chk("cbz_target", pc_target, 64'h40);
        @(posedge clk); #1;
        set_in(1, 0, 0, 1, 0, 0, 64'h0, 64'h0, 64'h40);
        @(negedge clk); chk("cbz_not_taken", pc_src, 0);
        @(posedge clk); #1;
        set_in(1, 0, 0, 0, 1, 0, 64'h0, 64'h0, 64'h80);
        @(negedge clk); chk("b_zero0", pc_src, 1);
        @(posedge clk); #1;
        set_in(1, 0, 0, 0, 1, 1, 64'h0, 64'h0, 64'h80);
        @(negedge clk); chk("b_zero1", pc_src, 1);
        @(posedge clk); #1;

        // Wrap-around
        drive(1, 0, 1, 0, 0, 0, 64'd8, 64'hAA, 64'h0);
        ld_check(64'd8 + 64'(DEPTH * 8), 64'hAA, "wrap");

        // Reset aborts an in-flight store
        drive(1, 0, 1, 0, 0, 0, 64'd16, 64'h5555_0000_1111, 64'h0);
        set_in(1, 0, 1, 0, 0, 0, 64'd16, 64'hDEAD_BEEF, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0);
        @(negedge clk);
        chk("abort_stall", stall, 0);
        chk("abort_rdv", rd_valid, 0);
        chk("abort_read_data", read_data, 64'h0);
        chk("abort_pc_src", pc_src, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ld_check(64'd16, 64'h5555_0000_1111, "abort_ld");

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            a = {$urandom, $urandom};
`ifdef DMEM_ALIGN_CHECK_EN
            a[2:0] = 3'b000;
`endif
            case ($urandom_range(0, 6))
                0: drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                         1'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom});
                1: drive(1, 0, 0, 0, 0, 1'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom});
                6: drive(1, 1, 1, 0, 0, 1'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom});
                default: begin
                    op = ops[$urandom_range(0, 3)];
                    drive(1, op == OP_LDUR, op == OP_STUR, op[10:3] == OP_CBZ, op[10:5] == OP_B,
                          1'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom});
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
